// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, control-word bit positions
// and the stall controller state encoding.
package pipe_pkg;

  localparam int NOP_INSTR    = 0;
  localparam int REGWRITE_BIT = 0;
  localparam int MEMREAD_BIT  = 1;
  localparam int MEMWRITE_BIT = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } stall_state_e;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset to zero, synchronous
// clear-to-value that takes priority over the load enable.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] clr_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (clr)
      q <= clr_val;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Load-use stall enforcement: freezes PC and IF/ID and feeds the requested
// number of bubbles into ID/EX; a branch flush overrides everything.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CTRL_W    = 8,
  parameter int PAYLOAD_W = 112,
  parameter int BUB_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_req,
  input  logic [BUB_W-1:0]     bubble_req,
  input  logic                 flush,
  input  logic [DATA_W-1:0]    if_pc,
  input  logic [DATA_W-1:0]    if_instr,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic [PAYLOAD_W-1:0] id_payload,
  output logic                 pc_we,
  output logic [DATA_W-1:0]    ifid_pc,
  output logic [DATA_W-1:0]    ifid_instr,
  output logic                 ifid_valid,
  output logic [CTRL_W-1:0]    idex_ctrl,
  output logic [PAYLOAD_W-1:0] idex_payload,
  output logic                 idex_valid,
  output logic [BUB_W-1:0]     bub_left
);

  localparam int IFID_W = 2 * DATA_W + 1;
  localparam int IDEX_W = CTRL_W + PAYLOAD_W + 1;

  stall_state_e     state_reg;
  logic [BUB_W-1:0] cnt_reg;

  logic hazard;
  logic front_hold;
  logic idex_bubble;

  assign hazard      = (state_reg == ST_RUN) && stall_req && (bubble_req != '0);
  assign front_hold  = hazard || (state_reg == ST_HOLD);
  assign pc_we       = flush || !front_hold;
  assign idex_bubble = flush || front_hold;
  assign bub_left    = cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else if (flush) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else if (hazard) begin
      cnt_reg   <= bubble_req - BUB_W'(1);
      state_reg <= (bubble_req > BUB_W'(1)) ? ST_HOLD : ST_RUN;
    end else if (state_reg == ST_HOLD) begin
      cnt_reg <= cnt_reg - BUB_W'(1);
      if (cnt_reg == BUB_W'(1))
        state_reg <= ST_RUN;
    end
  end

  // On flush the IF/ID PC keeps its old value; only the instruction is killed.
  logic [IFID_W-1:0] ifid_d, ifid_clr_val, ifid_q;
  assign ifid_d       = {if_pc, if_instr, 1'b1};
  assign ifid_clr_val = {ifid_pc, DATA_W'(NOP_INSTR), 1'b0};
  assign {ifid_pc, ifid_instr, ifid_valid} = ifid_q;

  pipe_reg #(.W(IFID_W)) u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pc_we),
    .clr     (flush),
    .clr_val (ifid_clr_val),
    .d       (ifid_d),
    .q       (ifid_q)
  );

  // A bubble zeroes control and valid but leaves the payload untouched.
  logic [IDEX_W-1:0] idex_d, idex_clr_val, idex_q;
  assign idex_d       = {id_ctrl, id_payload, ifid_valid};
  assign idex_clr_val = {{CTRL_W{1'b0}}, idex_payload, 1'b0};
  assign {idex_ctrl, idex_payload, idex_valid} = idex_q;

  pipe_reg #(.W(IDEX_W)) u_idex (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (1'b1),
    .clr     (idex_bubble),
    .clr_val (idex_clr_val),
    .d       (idex_d),
    .q       (idex_q)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: streaming, 1- and 3-bubble stalls,
// flush priority and asynchronous reset during HOLD.
module tb_pipe_stall_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         stall_req;
  logic [1:0]   bubble_req;
  logic         flush;
  logic [31:0]  if_pc;
  logic [31:0]  if_instr;
  logic [7:0]   id_ctrl;
  logic [111:0] id_payload;
  logic         pc_we;
  logic [31:0]  ifid_pc;
  logic [31:0]  ifid_instr;
  logic         ifid_valid;
  logic [7:0]   idex_ctrl;
  logic [111:0] idex_payload;
  logic         idex_valid;
  logic [1:0]   bub_left;

  int total = 0;
  int bad   = 0;

  pipe_stall_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_req    (stall_req),
    .bubble_req   (bubble_req),
    .flush        (flush),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .id_ctrl      (id_ctrl),
    .id_payload   (id_payload),
    .pc_we        (pc_we),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr),
    .ifid_valid   (ifid_valid),
    .idex_ctrl    (idex_ctrl),
    .idex_payload (idex_payload),
    .idex_valid   (idex_valid),
    .bub_left     (bub_left)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pcv(input int i);
    return 32'h100 + 32'(4 * i);
  endfunction
  function automatic logic [31:0] insv(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction
  function automatic logic [7:0] ctv(input int i);
    return 8'h10 + 8'(i);
  endfunction
  function automatic logic [111:0] pyv(input int i);
    return {16'hBEEF, 64'h0, 32'h5500 + 32'(i)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle (index i selects the fetch/decode values),
  // check the combinational pc_we, then advance past the next rising edge.
  task automatic cyc(input logic fl, input logic sr, input logic [1:0] br,
                     input int i, input logic exp_we, input string tag);
    flush      = fl;
    stall_req  = sr;
    bubble_req = br;
    if_pc      = pcv(i);
    if_instr   = insv(i);
    id_ctrl    = ctv(i);
    id_payload = pyv(i);
    #1;
    chk({tag, ".pc_we"}, 128'(pc_we), 128'(exp_we));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; stall_req = 1'b0; bubble_req = 2'd0;
    if_pc = '0; if_instr = '0; id_ctrl = '0; id_payload = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ifid_valid", 128'(ifid_valid), 128'(0));
    chk("rst.idex_valid", 128'(idex_valid), 128'(0));
    chk("rst.ifid_instr", 128'(ifid_instr), 128'(0));
    chk("rst.idex_ctrl",  128'(idex_ctrl),  128'(0));
    chk("rst.idex_pay",   128'(idex_payload), 128'(0));
    chk("rst.bub_left",   128'(bub_left),   128'(0));
    chk("rst.pc_we",      128'(pc_we),      128'(1));
    rst_n = 1'b1;

    // Some traffic, then reset mid-stream without a clock edge.
    cyc(0, 0, 0, 20, 1, "pre0");
    cyc(0, 0, 0, 21, 1, "pre1");
    chk("pre.idex_valid", 128'(idex_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst.ifid_valid", 128'(ifid_valid), 128'(0));
    chk("mid_rst.idex_valid", 128'(idex_valid), 128'(0));
    rst_n = 1'b1;

    // Stream 4 instructions with no hazards.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, i, 1, $sformatf("run%0d", i));
      chk($sformatf("run%0d.ifid_pc", i),    128'(ifid_pc),    128'(pcv(i)));
      chk($sformatf("run%0d.ifid_instr", i), 128'(ifid_instr), 128'(insv(i)));
      chk($sformatf("run%0d.ifid_valid", i), 128'(ifid_valid), 128'(1));
      chk($sformatf("run%0d.idex_ctrl", i),  128'(idex_ctrl),  128'(ctv(i)));
      chk($sformatf("run%0d.idex_pay", i),   128'(idex_payload), 128'(pyv(i)));
      chk($sformatf("run%0d.idex_valid", i), 128'(idex_valid), 128'(i > 0));
    end

    // Single-bubble hazard.
    cyc(0, 1, 1, 4, 0, "h1");
    chk("h1.ifid_pc",    128'(ifid_pc),    128'(pcv(3)));
    chk("h1.idex_ctrl",  128'(idex_ctrl),  128'(0));
    chk("h1.idex_valid", 128'(idex_valid), 128'(0));
    chk("h1.idex_pay",   128'(idex_payload), 128'(pyv(3)));
    chk("h1.bub_left",   128'(bub_left),   128'(0));
    cyc(0, 0, 0, 4, 1, "h1r");
    chk("h1r.idex_ctrl",  128'(idex_ctrl),  128'(ctv(4)));
    chk("h1r.idex_valid", 128'(idex_valid), 128'(1));
    chk("h1r.ifid_pc",    128'(ifid_pc),    128'(pcv(4)));

    // Three-bubble hazard; stall_req held during HOLD must not extend it.
    cyc(0, 1, 3, 5, 0, "h3a");
    chk("h3a.bub_left",   128'(bub_left),   128'(2));
    chk("h3a.idex_valid", 128'(idex_valid), 128'(0));
    chk("h3a.ifid_pc",    128'(ifid_pc),    128'(pcv(4)));
    cyc(0, 1, 3, 5, 0, "h3b");
    chk("h3b.bub_left",   128'(bub_left),   128'(1));
    chk("h3b.idex_ctrl",  128'(idex_ctrl),  128'(0));
    cyc(0, 1, 2, 5, 0, "h3c");
    chk("h3c.bub_left",   128'(bub_left),   128'(0));
    chk("h3c.idex_valid", 128'(idex_valid), 128'(0));
    chk("h3c.ifid_pc",    128'(ifid_pc),    128'(pcv(4)));
    cyc(0, 0, 0, 5, 1, "h3d");
    chk("h3d.idex_ctrl",  128'(idex_ctrl),  128'(ctv(5)));
    chk("h3d.idex_valid", 128'(idex_valid), 128'(1));
    chk("h3d.ifid_pc",    128'(ifid_pc),    128'(pcv(5)));

    // Flush together with an accepted hazard: flush wins.
    cyc(1, 1, 2, 6, 1, "fh");
    chk("fh.ifid_valid", 128'(ifid_valid), 128'(0));
    chk("fh.ifid_instr", 128'(ifid_instr), 128'(0));
    chk("fh.ifid_pc",    128'(ifid_pc),    128'(pcv(5)));
    chk("fh.idex_valid", 128'(idex_valid), 128'(0));
    chk("fh.idex_ctrl",  128'(idex_ctrl),  128'(0));
    chk("fh.bub_left",   128'(bub_left),   128'(0));
    cyc(0, 0, 0, 7, 1, "fhr");
    chk("fhr.ifid_pc",    128'(ifid_pc),    128'(pcv(7)));
    chk("fhr.ifid_valid", 128'(ifid_valid), 128'(1));
    chk("fhr.idex_valid", 128'(idex_valid), 128'(0));

    // Flush on the second cycle of a three-bubble HOLD.
    cyc(0, 1, 3, 8, 0, "fa");
    chk("fa.bub_left",   128'(bub_left),   128'(2));
    cyc(1, 0, 0, 8, 1, "fb");
    chk("fb.bub_left",   128'(bub_left),   128'(0));
    chk("fb.ifid_valid", 128'(ifid_valid), 128'(0));
    cyc(0, 0, 0, 9, 1, "fc");
    chk("fc.ifid_pc",    128'(ifid_pc),    128'(pcv(9)));
    chk("fc.ifid_valid", 128'(ifid_valid), 128'(1));

    // Asynchronous reset pulse mid-HOLD.
    cyc(0, 1, 3, 10, 0, "ra");
    chk("ra.bub_left", 128'(bub_left), 128'(2));
    stall_req = 1'b0; bubble_req = 2'd0;
    rst_n = 1'b0;
    #1;
    chk("ra.rst.bub_left",   128'(bub_left),   128'(0));
    chk("ra.rst.ifid_valid", 128'(ifid_valid), 128'(0));
    chk("ra.rst.idex_valid", 128'(idex_valid), 128'(0));
    chk("ra.rst.pc_we",      128'(pc_we),      128'(1));
    rst_n = 1'b1;
    cyc(0, 0, 0, 11, 1, "rb");
    chk("rb.ifid_valid", 128'(ifid_valid), 128'(1));
    chk("rb.ifid_pc",    128'(ifid_pc),    128'(pcv(11)));
    cyc(0, 0, 0, 12, 1, "rc");
    chk("rc.idex_valid", 128'(idex_valid), 128'(1));
    chk("rc.idex_ctrl",  128'(idex_ctrl),  128'(ctv(12)));
    chk("rc.bub_left",   128'(bub_left),   128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
